// File: rtl/rmt_axis_pkg.sv
// rtl/rmt_axis_pkg.sv - shared tuser layout and drop-filter state encoding
package rmt_axis_pkg;

  // Default stream geometry of the rmt pipeline
  localparam int unsigned AXIS_DATA_WIDTH_DEF  = 512;
  localparam int unsigned AXIS_TUSER_WIDTH_DEF = 128;
  localparam int unsigned STAT_CNT_WIDTH_DEF   = 32;

  // tuser field positions (first beat of a packet)
  localparam int unsigned TUSER_PKT_LEN_LSB    = 0;
  localparam int unsigned TUSER_PKT_LEN_WIDTH  = 16;
  localparam int unsigned TUSER_SRC_PORT_LSB   = 16;
  localparam int unsigned TUSER_SRC_PORT_WIDTH = 8;
  localparam int unsigned TUSER_DST_PORT_LSB   = 24;
  localparam int unsigned TUSER_DST_PORT_WIDTH = 8;
  localparam int unsigned TUSER_DROP_BIT       = 127;

  // Packet-level position of the drop filter within the input stream
  typedef enum logic [1:0] {
    S_FIRST = 2'd0,
    S_FWD   = 2'd1,
    S_DROP  = 2'd2
  } filt_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - two-entry registered stream stage with registered tready
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] in_tdata_i,
  input  logic             in_tvalid_i,
  output logic             in_tready_o,
  output logic [WIDTH-1:0] out_tdata_o,
  output logic             out_tvalid_o,
  input  logic             out_tready_i
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             ready_q, ready_d;
  logic             out_fire;
  logic             in_push;

  assign out_fire = main_valid_q & out_tready_i;
  assign in_push  = in_tvalid_i & ready_q;

  // Next-state of the two entries: main feeds the output, skid catches the one
  // beat that can arrive in the cycle the downstream stalls.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      // input is blocked while skid holds a beat, so only draining can happen
      if (out_fire) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_push) begin
      if (!main_valid_q || out_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = in_tdata_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_tdata_i;
      end
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end
    ready_d = ~skid_valid_d;
  end

  // Entry and ready registers; ready stays low for the whole reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign in_tready_o  = ready_q;
  assign out_tdata_o  = main_data_q;
  assign out_tvalid_o = main_valid_q;

endmodule

// File: rtl/rmt_drop_filter.sv
// rtl/rmt_drop_filter.sv - discards packets flagged for drop on their first beat
module rmt_drop_filter
  import rmt_axis_pkg::*;
#(
  parameter int unsigned C_AXIS_DATA_WIDTH  = AXIS_DATA_WIDTH_DEF,
  parameter int unsigned C_AXIS_TUSER_WIDTH = AXIS_TUSER_WIDTH_DEF,
  parameter int unsigned DROP_BIT           = TUSER_DROP_BIT,
  parameter int unsigned CNT_WIDTH          = STAT_CNT_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [CNT_WIDTH-1:0]            fwd_pkt_cnt,
  output logic [CNT_WIDTH-1:0]            drop_pkt_cnt
);

  localparam int unsigned KEEP_W = C_AXIS_DATA_WIDTH / 8;
  localparam int unsigned PAY_W  = C_AXIS_DATA_WIDTH + KEEP_W + C_AXIS_TUSER_WIDTH + 1;

  filt_state_e          state_q;
  logic [CNT_WIDTH-1:0] drop_cnt_q;
  logic [CNT_WIDTH-1:0] fwd_cnt_q, fwd_cnt_d;

  logic             in_ready;
  logic             beat_acc;
  logic             drop_flag;
  logic             fwd_beat;
  logic             out_last_fire;
  logic [PAY_W-1:0] in_payload;
  logic [PAY_W-1:0] out_payload;

  assign beat_acc  = s_axis_tvalid & in_ready;
  assign drop_flag = s_axis_tuser[DROP_BIT];

  // Only the first beat's flag matters; later beats follow the packet's fate
  assign fwd_beat = (state_q == S_FWD) || ((state_q == S_FIRST) && !drop_flag);

  // Packet-position FSM and drop counter, advanced on accepted beats only
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_FIRST;
      drop_cnt_q <= '0;
    end else if (beat_acc) begin
      case (state_q)
        S_FIRST: begin
          if (drop_flag) begin
            drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
            state_q    <= s_axis_tlast ? S_FIRST : S_DROP;
          end else begin
            state_q    <= s_axis_tlast ? S_FIRST : S_FWD;
          end
        end
        S_FWD, S_DROP: begin
          if (s_axis_tlast) state_q <= S_FIRST;
        end
        default: state_q <= S_FIRST;
      endcase
    end
  end

  // A packet counts as forwarded once its last beat leaves the block
  assign out_last_fire = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  always_comb begin
    fwd_cnt_d = fwd_cnt_q;
    if (out_last_fire) fwd_cnt_d = fwd_cnt_q + CNT_WIDTH'(1);
  end

  // Forwarded packet counter register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      fwd_cnt_q <= '0;
    end else begin
      fwd_cnt_q <= fwd_cnt_d;
    end
  end

  assign in_payload = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};

  // Dropped beats are consumed without ever entering the output stage
  axis_skid_buffer #(
    .WIDTH (PAY_W)
  ) u_out_stage (
    .clk_i        (clk),
    .rst_ni       (aresetn),
    .in_tdata_i   (in_payload),
    .in_tvalid_i  (s_axis_tvalid & fwd_beat),
    .in_tready_o  (in_ready),
    .out_tdata_o  (out_payload),
    .out_tvalid_o (m_axis_tvalid),
    .out_tready_i (m_axis_tready)
  );

  assign s_axis_tready = in_ready;
  assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = out_payload;
  assign fwd_pkt_cnt   = fwd_cnt_q;
  assign drop_pkt_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_rmt_drop_filter.sv
// tb/tb_rmt_drop_filter.sv - self-checking bench for rmt_drop_filter
module tb_rmt_drop_filter;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int UW = 128;
  localparam int BW = DW + KW + UW + 1;

  logic          clk = 1'b0;
  logic          aresetn = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic [UW-1:0] s_tuser = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          m_tready = 1'b1;

  logic          s_tready, m_tvalid, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic [31:0]   fwd_cnt, drop_cnt;

  logic          w_s_tready, w_m_tvalid, w_m_tlast;
  logic [DW-1:0] w_m_tdata;
  logic [KW-1:0] w_m_tkeep;
  logic [UW-1:0] w_m_tuser;
  logic [3:0]    w_fwd_cnt, w_drop_cnt;

  always #5 clk = ~clk;

  rmt_drop_filter dut (
    .clk (clk), .aresetn (aresetn),
    .s_axis_tdata (s_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tuser (s_tuser),
    .s_axis_tvalid (s_tvalid), .s_axis_tready (s_tready), .s_axis_tlast (s_tlast),
    .m_axis_tdata (m_tdata), .m_axis_tkeep (m_tkeep), .m_axis_tuser (m_tuser),
    .m_axis_tvalid (m_tvalid), .m_axis_tready (m_tready), .m_axis_tlast (m_tlast),
    .fwd_pkt_cnt (fwd_cnt), .drop_pkt_cnt (drop_cnt)
  );

  rmt_drop_filter #(.CNT_WIDTH (4)) dut_w4 (
    .clk (clk), .aresetn (aresetn),
    .s_axis_tdata (s_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tuser (s_tuser),
    .s_axis_tvalid (s_tvalid), .s_axis_tready (w_s_tready), .s_axis_tlast (s_tlast),
    .m_axis_tdata (w_m_tdata), .m_axis_tkeep (w_m_tkeep), .m_axis_tuser (w_m_tuser),
    .m_axis_tvalid (w_m_tvalid), .m_axis_tready (m_tready), .m_axis_tlast (w_m_tlast),
    .fwd_pkt_cnt (w_fwd_cnt), .drop_pkt_cnt (w_drop_cnt)
  );

  // Model: beats of clean packets in acceptance order, plus packet counts
  logic [BW-1:0] exp_q[$];
  int unsigned   exp_fwd = 0;
  int unsigned   exp_drop = 0;
  int            checks = 0;
  int            errors = 0;
  int            stall_cnt = 0;
  bit            prev_stall = 1'b0;
  logic [BW-1:0] prev_beat = '0;
  bit            rec_ready[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] mk_beat(input int pid, input int b, input int n, input bit drop);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
    for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = {pid[7:0], b[7:0], 16'(i * 313 + pid)};
    l = (b == n - 1);
    k = '1;
    if (l) k = (pid % 4 == 3) ? '0 : ({KW{1'b1}} >> (pid % 8));
    u = '0;
    u[31:0] = {pid[15:0], b[15:0]};
    u[UW-1] = (b == 0) ? drop : 1'b1;
    return {l, u, k, d};
  endfunction

  // Compare process: every cycle out of reset, checks outputs against the model
  always @(negedge clk) begin
    logic [BW-1:0] cur;
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      cur = {m_tlast, m_tuser, m_tkeep, m_tdata};
      chk("fwd_cnt", 64'(fwd_cnt), 64'(exp_fwd));
      chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      chk("fwd_cnt_w4", 64'(w_fwd_cnt), 64'(exp_fwd % 16));
      chk("drop_cnt_w4", 64'(w_drop_cnt), 64'(exp_drop % 16));
      chk("m_tvalid_vs_pending", 64'(m_tvalid), 64'(exp_q.size() != 0));
      chk("pending_le_2", 64'(exp_q.size() <= 2), 64'd1);
      if (prev_stall) begin
        checks++;
        if (!m_tvalid || cur !== prev_beat) begin
          errors++;
          $display("FAIL stall_hold: valid %0b beat %h expected %h", m_tvalid, cur, prev_beat);
        end
      end
      if (m_tvalid && exp_q.size() != 0) begin
        checks++;
        if (cur !== exp_q[0]) begin
          errors++;
          $display("FAIL beat: got %h expected %h", cur, exp_q[0]);
        end
        if (m_tready) begin
          if (exp_q[0][BW-1]) exp_fwd++;
          void'(exp_q.pop_front());
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = cur;
    end
  end

  task automatic send_beat(input logic [BW-1:0] beat, input bit fwd, input bit first_drop);
    bit acc;
    acc = 1'b0;
    {s_tlast, s_tuser, s_tkeep, s_tdata} = beat;
    s_tvalid = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      if (!acc) stall_cnt++;
    end
    if (acc) begin
      if (fwd) exp_q.push_back(beat);
      if (first_drop) exp_drop++;
    end else begin
      chk("send_timeout", 64'd0, 64'd1);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int pid, input int n, input bit drop);
    for (int b = 0; b < n; b++) send_beat(mk_beat(pid, b, n, drop), !drop, drop && b == 0);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    exp_q.delete();
    exp_fwd  = 0;
    exp_drop = 0;
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_fwd_cnt", 64'(fwd_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [BW-1:0] b1;
    logic [DW-1:0] d1;
    #1;
    aresetn = 1'b0;
    #1;
    chk("init_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("init_m_tdata_lo", m_tdata[63:0], 64'd0);
    chk("init_s_tready", 64'(s_tready), 64'd0);
    chk("init_fwd_cnt", 64'(fwd_cnt), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_release", 64'(s_tready), 64'd1);
    @(posedge clk);
    #1;

    // 1: single clean beat, visible one cycle after acceptance
    d1 = '0;
    for (int i = 0; i < DW / 64; i++) d1[64*i +: 64] = 64'h0123_4567_89ab_cdef ^ 64'(i);
    b1 = {1'b1, {UW{1'b0}}, {KW{1'b1}}, d1};
    send_beat(b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_latency_valid", 64'(m_tvalid), 64'd1);
    chk("t1_tdata_lo", m_tdata[63:0], 64'h0123_4567_89ab_cdef);
    chk("t1_tdata_hi", m_tdata[DW-1 -: 64], 64'h0123_4567_89ab_cdef ^ 64'd7);
    drain();
    chk("t1_fwd", 64'(fwd_cnt), 64'd1);
    chk("t1_drop", 64'(drop_cnt), 64'd0);

    // 2: dropped 3-beat packet then a clean 2-beat one
    stall_cnt = 0;
    send_pkt(2, 3, 1'b1);
    chk("t2_no_stall", 64'(stall_cnt), 64'd0);
    drain();
    chk("t2_drop", 64'(drop_cnt), 64'd1);
    chk("t2_fwd_before", 64'(fwd_cnt), 64'd1);
    send_pkt(3, 2, 1'b0);
    drain();
    chk("t2_fwd", 64'(fwd_cnt), 64'd2);

    // 3: back-to-back forward/drop/forward/drop
    stall_cnt = 0;
    send_pkt(4, 2, 1'b0);
    send_pkt(5, 2, 1'b1);
    send_pkt(6, 2, 1'b0);
    send_pkt(7, 2, 1'b1);
    chk("t3_no_stall", 64'(stall_cnt), 64'd0);
    drain();
    chk("t3_fwd", 64'(fwd_cnt), 64'd4);
    chk("t3_drop", 64'(drop_cnt), 64'd3);

    // 4: downstream ready pattern 1,0,0,1,0,1 under a 4-beat packet
    fork
      begin
        bit pat[6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
          m_tready = pat[k];
          @(negedge clk);
          rec_ready[k] = s_tready;
          @(posedge clk);
          #1;
        end
        m_tready = 1'b1;
      end
      send_pkt(8, 4, 1'b0);
    join
    chk("t4_rdy0", 64'(rec_ready[0]), 64'd1);
    chk("t4_rdy1", 64'(rec_ready[1]), 64'd1);
    chk("t4_rdy2", 64'(rec_ready[2]), 64'd0);
    chk("t4_rdy3", 64'(rec_ready[3]), 64'd0);
    chk("t4_rdy4", 64'(rec_ready[4]), 64'd1);
    chk("t4_rdy5", 64'(rec_ready[5]), 64'd0);
    drain();
    chk("t4_fwd", 64'(fwd_cnt), 64'd5);

    // 5: reset while beat 2 of a clean 3-beat packet is offered
    send_beat(mk_beat(9, 0, 3, 1'b0), 1'b1, 1'b0);
    {s_tlast, s_tuser, s_tkeep, s_tdata} = mk_beat(9, 1, 3, 1'b0);
    s_tvalid = 1'b1;
    pulse_reset();
    send_pkt(10, 1, 1'b1);
    send_pkt(11, 2, 1'b0);
    drain();
    chk("t5_drop", 64'(drop_cnt), 64'd1);
    chk("t5_fwd", 64'(fwd_cnt), 64'd1);

    // 6: 17 single-beat packets wrap the 4-bit counter to 1
    pulse_reset();
    for (int p = 20; p < 37; p++) send_pkt(p, 1, 1'b0);
    drain();
    chk("t6_fwd32", 64'(fwd_cnt), 64'd17);
    chk("t6_fwd4_wrap", 64'(w_fwd_cnt), 64'd1);
    chk("t6_drop", 64'(drop_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
